// File: rtl/vram_arbiter.sv
// vram_arbiter: two-requester (video, host) front end for a single-port,
// 1-cycle-read VRAM. Video has strict priority. Every accepted access is
// issued to the RAM one cycle later. Read data returns with a fixed
// 3-cycle latency and goes only to the port that made the request.
// Optional feature: define VRAM_ARB_STARVE_GUARD_EN to force a host grant
// after STARVE_LIMIT consecutive host denials.
module vram_arbiter #(
  parameter int ADDR_W       = 14,
  parameter int DATA_W       = 16,
  parameter int STARVE_LIMIT = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic              vid_ack,
  output logic              vid_rvalid,
  output logic [DATA_W-1:0] vid_rdata,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_ack,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] host_rdata,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [1:0] TAG_NONE = 2'd0;
  localparam logic [1:0] TAG_VID  = 2'd1;
  localparam logic [1:0] TAG_HOST = 2'd2;

  logic        force_host;
  logic        we_q;
  logic [1:0]  tag_pipe [2];

`ifdef VRAM_ARB_STARVE_GUARD_EN
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  logic [CNT_W-1:0] starve_cnt;

  // Host overrides video once it has been denied STARVE_LIMIT times in a row.
  assign force_host = host_req && (starve_cnt == CNT_W'(STARVE_LIMIT));

  // Count consecutive host denials; a host handshake restarts the count.
  always_ff @(posedge clk) begin
    if (rst)
      starve_cnt <= '0;
    else if (host_req && host_ack)
      starve_cnt <= '0;
    else if (host_req && (starve_cnt != CNT_W'(STARVE_LIMIT)))
      starve_cnt <= starve_cnt + 1'b1;
  end
`else
  // The guard is compiled out, so priority is strict. STARVE_LIMIT stays in
  // the parameter list so both builds have the same interface.
  localparam bit GUARD_OFF = (STARVE_LIMIT >= 0);
  assign force_host = !GUARD_OFF;
`endif

  // Grants depend only on requests, reset and arbiter state, never on
  // address or data.
  assign vid_ack  = !rst && vid_req && !force_host;
  assign host_ack = !rst && host_req && (!vid_req || force_host);

  // A write that was registered just before reset is gated off during the
  // reset cycle, so it never reaches the RAM.
  assign mem_we = we_q && !rst;

  // Register the winner's access for the RAM. With no handshake, the
  // address and data hold their values.
  always_ff @(posedge clk) begin
    if (rst) begin
      we_q      <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else if (vid_ack) begin
      we_q      <= 1'b0;
      mem_addr  <= vid_addr;
    end else if (host_ack) begin
      we_q      <= host_we;
      mem_addr  <= host_addr;
      mem_wdata <= host_wdata;
    end else begin
      we_q      <= 1'b0;
    end
  end

  // Source tag for each accepted read. Stage 0 lines up with the RAM issue
  // cycle; stage 1 lines up with the cycle in which mem_rdata is valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_pipe[0] <= TAG_NONE;
      tag_pipe[1] <= TAG_NONE;
    end else begin
      if (vid_ack)
        tag_pipe[0] <= TAG_VID;
      else if (host_ack && !host_we)
        tag_pipe[0] <= TAG_HOST;
      else
        tag_pipe[0] <= TAG_NONE;
      tag_pipe[1] <= tag_pipe[0];
    end
  end

  // Capture the RAM data for the tagged owner. Each port's rdata holds
  // until that port's next return.
  always_ff @(posedge clk) begin
    if (rst) begin
      vid_rvalid  <= 1'b0;
      host_rvalid <= 1'b0;
      vid_rdata   <= '0;
      host_rdata  <= '0;
    end else begin
      vid_rvalid  <= (tag_pipe[1] == TAG_VID);
      host_rvalid <= (tag_pipe[1] == TAG_HOST);
      if (tag_pipe[1] == TAG_VID)  vid_rdata  <= mem_rdata;
      if (tag_pipe[1] == TAG_HOST) host_rdata <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter. A behavioural 1-cycle RAM sits behind the
// DUT. Each accepted read pushes its expected port, data and return cycle
// onto a queue, and a negedge monitor pops and compares the returns.
module tb_vram_arbiter;
  localparam int ADDR_W = 14;
  localparam int DATA_W = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              vid_req, vid_ack, vid_rvalid;
  logic [ADDR_W-1:0] vid_addr;
  logic [DATA_W-1:0] vid_rdata;
  logic              host_req, host_we, host_ack, host_rvalid;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_wdata, host_rdata;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  vram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIMIT(8)) dut (
    .clk(clk), .rst(rst),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack),
    .vid_rvalid(vid_rvalid), .vid_rdata(vid_rdata),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_ack(host_ack),
    .host_rvalid(host_rvalid), .host_rdata(host_rdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  logic [DATA_W-1:0] ram    [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] shadow [0:(1<<ADDR_W)-1];

  // Single-port RAM with a 1-cycle read.
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit                port;   // 0 = video, 1 = host
    logic [DATA_W-1:0] data;
    int                due;
  } exp_t;
  exp_t exp_q[$];

  int checks = 0;
  int failures = 0;
  int we_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Scoreboard and per-cycle protocol checks.
  always @(negedge clk) begin
    exp_t e;
    if (mem_we) we_cnt++;
    chk("ack_exclusive", {31'd0, vid_ack && host_ack}, 32'd0);
    chk("ack_without_req", {31'd0, (vid_ack && !vid_req) || (host_ack && !host_req)}, 32'd0);
    if (vid_rvalid || host_rvalid) begin
      if (exp_q.size() == 0) begin
        chk("rvalid_unexpected", {30'd0, vid_rvalid, host_rvalid}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("rvalid_port", {30'd0, vid_rvalid, host_rvalid}, e.port ? 32'd1 : 32'd2);
        chk("rdata", {16'd0, e.port ? host_rdata : vid_rdata}, {16'd0, e.data});
        chk("return_cycle", cyc, e.due);
      end
    end else if (exp_q.size() != 0 && exp_q[0].due <= cyc) begin
      e = exp_q.pop_front();
      chk("rvalid_missing", {30'd0, vid_rvalid, host_rvalid}, e.port ? 32'd1 : 32'd2);
    end
    if (rst) exp_q.delete();
    if (vid_ack) exp_q.push_back('{1'b0, shadow[vid_addr], cyc + 3});
    if (host_ack) begin
      if (host_we) shadow[host_addr] = host_wdata;
      else exp_q.push_back('{1'b1, shadow[host_addr], cyc + 3});
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_mem_we"},      {31'd0, mem_we}, 32'd0);
    chk({tag, "_mem_addr"},    {18'd0, mem_addr}, 32'd0);
    chk({tag, "_mem_wdata"},   {16'd0, mem_wdata}, 32'd0);
    chk({tag, "_rvalids"},     {30'd0, vid_rvalid, host_rvalid}, 32'd0);
    chk({tag, "_vid_rdata"},   {16'd0, vid_rdata}, 32'd0);
    chk({tag, "_host_rdata"},  {16'd0, host_rdata}, 32'd0);
  endtask

  logic [19:0] hv;
  logic [19:0] hv_exp;
  int we0;

  initial begin
    ram[0] = 16'h1111; ram[1] = 16'h2222; ram[2] = 16'hC0DE; ram[5] = 16'hBEEF;
    shadow[0] = 16'h1111; shadow[1] = 16'h2222; shadow[2] = 16'hC0DE; shadow[5] = 16'hBEEF;
    rst = 1'b1; vid_req = 1'b1; vid_addr = '0;
    host_req = 1'b1; host_we = 1'b0; host_addr = '0; host_wdata = '0;

    // Requests are ignored while reset is high.
    @(negedge clk);
    chk("rst_vid_ack", {31'd0, vid_ack}, 32'd0);
    chk("rst_host_ack", {31'd0, host_ack}, 32'd0);
    step();
    rst = 1'b0; vid_req = 1'b0; host_req = 1'b0;
    @(negedge clk);
    chk_reset_vals("post_rst");

    // A single video read returns 0xBEEF three cycles later.
    step(); vid_req = 1'b1; vid_addr = 14'h0005;
    @(negedge clk);
    chk("vid_ack", {31'd0, vid_ack}, 32'd1);
    chk("vid_host_ack0", {31'd0, host_ack}, 32'd0);
    step(); vid_req = 1'b0;
    @(negedge clk);
    chk("vid_mem_addr", {18'd0, mem_addr}, 32'h5);
    chk("vid_mem_we", {31'd0, mem_we}, 32'd0);
    step(); step();
    @(negedge clk);
    chk("vid_rvalid", {31'd0, vid_rvalid}, 32'd1);
    chk("vid_rdata", {16'd0, vid_rdata}, 32'hBEEF);
    chk("vid_host_rvalid0", {31'd0, host_rvalid}, 32'd0);
    step();
    @(negedge clk);
    chk("vid_rvalid_pulse", {31'd0, vid_rvalid}, 32'd0);
    chk("vid_rdata_hold", {16'd0, vid_rdata}, 32'hBEEF);

    // Host write followed by a read of the same address.
    we0 = we_cnt;
    step(); host_req = 1'b1; host_we = 1'b1; host_addr = 14'h3FFF; host_wdata = 16'h1234;
    @(negedge clk);
    chk("hw_ack", {31'd0, host_ack}, 32'd1);
    step(); host_we = 1'b0;
    @(negedge clk);
    chk("hr_ack", {31'd0, host_ack}, 32'd1);
    chk("hw_mem_we", {31'd0, mem_we}, 32'd1);
    chk("hw_mem_addr", {18'd0, mem_addr}, 32'h3FFF);
    chk("hw_mem_wdata", {16'd0, mem_wdata}, 32'h1234);
    step(); host_req = 1'b0;
    @(negedge clk);
    chk("hr_mem_we", {31'd0, mem_we}, 32'd0);
    step(); step();
    @(negedge clk);
    chk("hr_rvalid", {31'd0, host_rvalid}, 32'd1);
    chk("hr_rdata", {16'd0, host_rdata}, 32'h1234);
    chk("hw_we_once", we_cnt - we0, 32'd1);

    // Simultaneous requests: video first, then host.
    step(); vid_req = 1'b1; vid_addr = 14'h0005; host_req = 1'b1; host_we = 1'b0; host_addr = 14'h0002;
    @(negedge clk);
    chk("both_vid_ack", {31'd0, vid_ack}, 32'd1);
    chk("both_host_wait", {31'd0, host_ack}, 32'd0);
    step(); vid_req = 1'b0;
    @(negedge clk);
    chk("both_host_ack", {31'd0, host_ack}, 32'd1);
    step(); host_req = 1'b0;
    repeat (4) step();

    // Interleaved back-to-back reads: video 0, host 2, video 1.
    vid_req = 1'b1; vid_addr = 14'h0000;
    step(); vid_req = 1'b0; host_req = 1'b1; host_we = 1'b0; host_addr = 14'h0002;
    step(); host_req = 1'b0; vid_req = 1'b1; vid_addr = 14'h0001;
    step(); vid_req = 1'b0;
    @(negedge clk);
    chk("il_ret0_vid", {31'd0, vid_rvalid}, 32'd1);
    chk("il_ret0_data", {16'd0, vid_rdata}, 32'h1111);
    step();
    @(negedge clk);
    chk("il_ret1_host", {30'd0, vid_rvalid, host_rvalid}, 32'd1);
    chk("il_ret1_data", {16'd0, host_rdata}, 32'hC0DE);
    step();
    @(negedge clk);
    chk("il_ret2_vid", {30'd0, vid_rvalid, host_rvalid}, 32'd2);
    chk("il_ret2_data", {16'd0, vid_rdata}, 32'h2222);
    repeat (3) step();

    // Both requests held continuously.
    vid_req = 1'b1; vid_addr = 14'h0001; host_req = 1'b1; host_we = 1'b0; host_addr = 14'h0002;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      hv[i] = host_ack;
      step();
    end
    vid_req = 1'b0; host_req = 1'b0;
`ifdef VRAM_ARB_STARVE_GUARD_EN
    hv_exp = 20'h0;
    hv_exp[8] = 1'b1;
    hv_exp[17] = 1'b1;
`else
    hv_exp = 20'h0;
`endif
    chk("starve_pattern", {12'd0, hv}, {12'd0, hv_exp});
    repeat (5) step();

    // A write registered for the reset cycle never reaches the RAM.
    host_req = 1'b1; host_we = 1'b1; host_addr = 14'h0100; host_wdata = 16'hAAAA;
    @(negedge clk);
    chk("sup_ack", {31'd0, host_ack}, 32'd1);
    step(); host_req = 1'b0; host_we = 1'b0; rst = 1'b1;
    @(negedge clk);
    chk("sup_mem_we", {31'd0, mem_we}, 32'd0);
    step(); rst = 1'b0;
    @(negedge clk);
    chk_reset_vals("sup_rst");

    // Reset right after a video read handshake cancels that read.
    step(); vid_req = 1'b1; vid_addr = 14'h0005;
    @(negedge clk);
    chk("cancel_ack", {31'd0, vid_ack}, 32'd1);
    step(); rst = 1'b1;
    @(negedge clk);
    chk("cancel_rst_ack", {31'd0, vid_ack}, 32'd0);
    step(); rst = 1'b0; vid_req = 1'b0;
    @(negedge clk);
    chk_reset_vals("cancel_rst");
    for (int k = 0; k < 5; k++) begin
      step();
      @(negedge clk);
      chk("cancel_no_rvalid", {31'd0, vid_rvalid}, 32'd0);
    end

    for (int k = 0; k < 20 && exp_q.size() != 0; k++) step();
    chk("scoreboard_empty", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
